// File: rtl/vga_pkg.sv
// Shared widths, default screen geometry and colour constants for the bounce generator.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int ROW_W         = 9;
    localparam int COL_W         = 10;
    localparam int RGB_W         = 3;

    localparam logic [RGB_W-1:0] BLACK = 3'b000;
    localparam logic [RGB_W-1:0] RED   = 3'b100;
    localparam logic [RGB_W-1:0] WHITE = 3'b111;
    localparam logic [RGB_W-1:0] BLUE  = 3'b001;

    // Step once, then keep stepping past black and the background so the box never disappears.
    // Only two values are excluded, so at most two extra steps are ever needed.
    function automatic logic [RGB_W-1:0] next_colour(input logic [RGB_W-1:0] cur,
                                                     input logic [RGB_W-1:0] bg);
        logic [RGB_W-1:0] n;
        n = cur + 3'd1;
        for (int i = 0; i < 2; i++) begin
            if (n == BLACK || n == bg) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position/direction register and edge bounce detection.
module vga_bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] pos_o,
    output logic             bounce_o
);

    // Compares run one bit wider so pos + SIZE + STEP can never wrap.
    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0] MAX_POS = EW'(LIMIT - SIZE);
    localparam logic [EW-1:0] LIMIT_E = EW'(LIMIT);
    localparam logic [EW-1:0] REACH_E = EW'(SIZE + STEP);
    localparam logic [EW-1:0] STEP_E  = EW'(STEP);

    logic [WIDTH-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;      // 1 = increasing
    logic [EW-1:0]    pos_e;
    logic             hit_hi, hit_lo;

    assign pos_e  = {1'b0, pos_q};
    assign hit_hi = dir_q && ((pos_e + REACH_E) > LIMIT_E);
    assign hit_lo = !dir_q && (pos_e < STEP_E);

    always_comb begin
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_o = 1'b0;
        if (step_i) begin
            if (hit_hi) begin
                pos_d    = MAX_POS[WIDTH-1:0];
                dir_d    = 1'b0;
                bounce_o = 1'b1;
            end else if (hit_lo) begin
                pos_d    = '0;
                dir_d    = 1'b1;
                bounce_o = 1'b1;
            end else if (dir_q) begin
                pos_d = pos_q + STEP_E[WIDTH-1:0];
            end else begin
                pos_d = pos_q - STEP_E[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pos_q <= '0;
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-box pixel source for vgaDriver: frame tick from vSync, colour on bounce, registered pixel.
// Define VGA_BOUNCE_BORDER_EN to draw a white one-pixel frame around the visible area.
module vga_bounce_gen
    import vga_pkg::*;
#(
    parameter int               H_VISIBLE = H_VISIBLE_DEF,
    parameter int               V_VISIBLE = V_VISIBLE_DEF,
    parameter int               BOX_SIZE  = 32,
    parameter int               STEP      = 2,
    parameter logic [RGB_W-1:0] BG_COLOR  = BLUE
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] column_i,
    input  logic             vSync_i,
    output logic [RGB_W-1:0] rgb_o,
    output logic             bounce_o
);

    localparam int CW = COL_W + 1;
    localparam int RW = ROW_W + 1;

    logic             vs_prev_q;
    logic             tick, move;
    logic [COL_W-1:0] box_x;
    logic [ROW_W-1:0] box_y;
    logic             hit_x, hit_y;
    logic [RGB_W-1:0] colour_q, colour_d;
    logic             bounce_q, bounce_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // vSync falling edge; box only moves inside the sync pulse, never during visible lines.
    assign tick = vs_prev_q && !vSync_i;
    assign move = tick && enable_i;

    vga_bounce_axis #(
        .LIMIT (H_VISIBLE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .WIDTH (COL_W)
    ) u_axis_x (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .step_i   (move),
        .pos_o    (box_x),
        .bounce_o (hit_x)
    );

    vga_bounce_axis #(
        .LIMIT (V_VISIBLE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .WIDTH (ROW_W)
    ) u_axis_y (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .step_i   (move),
        .pos_o    (box_y),
        .bounce_o (hit_y)
    );

    // A corner hit bounces both axes at once but still counts as one colour step.
    always_comb begin
        bounce_d = hit_x || hit_y;
        colour_d = colour_q;
        if (bounce_d) begin
            colour_d = next_colour(colour_q, BG_COLOR);
        end
    end

    logic [CW-1:0] col_e, box_x_e;
    logic [RW-1:0] row_e, box_y_e;
    logic          visible, in_box, border;

    assign col_e   = {1'b0, column_i};
    assign row_e   = {1'b0, row_i};
    assign box_x_e = {1'b0, box_x};
    assign box_y_e = {1'b0, box_y};

    assign visible = (col_e < CW'(H_VISIBLE)) && (row_e < RW'(V_VISIBLE));
    assign in_box  = (col_e >= box_x_e) && (col_e < (box_x_e + CW'(BOX_SIZE))) &&
                     (row_e >= box_y_e) && (row_e < (box_y_e + RW'(BOX_SIZE)));

`ifdef VGA_BOUNCE_BORDER_EN
    assign border = (col_e == CW'(0)) || (col_e == CW'(H_VISIBLE - 1)) ||
                    (row_e == RW'(0)) || (row_e == RW'(V_VISIBLE - 1));
`else
    assign border = 1'b0;
`endif

    always_comb begin
        rgb_d = BG_COLOR;
        if (!visible) begin
            rgb_d = BLACK;
        end else if (border) begin
            rgb_d = WHITE;
        end else if (in_box) begin
            rgb_d = colour_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vs_prev_q <= 1'b1;
            colour_q  <= RED;
            bounce_q  <= 1'b0;
            rgb_q     <= BLACK;
        end else begin
            vs_prev_q <= vSync_i;
            colour_q  <= colour_d;
            bounce_q  <= bounce_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb_o    = rgb_q;
    assign bounce_o = bounce_q;

endmodule
